kamikaze_mem_arbiter: RTL and testbench

- Arbitrates one shared 32-bit pipelined memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between kamikaze_fetch / the LSU and the external memory bus.
- Issues at most one request per cycle and returns responses in order to their owners, using an owner FIFO.
- Supports an IF flush: fetch responses already in flight are discarded after a PC redirect.

---
 rtl/kamikaze_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_kamikaze_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/kamikaze_mem_arbiter.sv
// Shares one pipelined 32-bit memory port between instruction fetch (IF) and load/store (LS).
// Responses return in order and are routed through an owner FIFO; IF flush drops stale fetch data.
module kamikaze_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);

  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [STV_W-1:0]           starve_cnt;
  logic [MAX_OUTSTANDING-1:0] own_ls;
  logic [MAX_OUTSTANDING-1:0] discard;
  logic [MAX_OUTSTANDING-1:0] occupied;

  logic full;
  logic empty;
  logic starve_hit;
  logic sel_ls;
  logic sel_if;
  logic issue;
  logic gnt_if;
  logic gnt_ls;
  logic push;
  logic pop;
  logic head_ls;
  logic head_discard;

  assign full       = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty      = (count == '0);
  assign starve_hit = if_req_i & (starve_cnt == STV_W'(STARVE_LIMIT));
  assign sel_ls     = ls_req_i & ~starve_hit;
  assign sel_if     = if_req_i & ~sel_ls;
  assign issue      = (sel_ls | sel_if) & ~full;
  assign gnt_ls     = sel_ls & ~full & mem_gnt_i;
  assign gnt_if     = sel_if & ~full & mem_gnt_i;
  assign push       = gnt_ls | gnt_if;
  // A response with nothing outstanding is a bus protocol error and is dropped.
  assign pop        = mem_rvalid_i & ~empty;

  assign head_ls      = own_ls[rd_ptr];
  assign head_discard = discard[rd_ptr];

  // Slot i is live when its distance from the read pointer is below the fill count.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      logic [PTR_W-1:0] offs;
      offs = PTR_W'(i) - rd_ptr;
      occupied[i] = ({{(CNT_W-PTR_W){1'b0}}, offs} < count);
    end
  end

  // Every output is forced low while reset is asserted, including the data mirrors.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;
    if_rdata_o  = 32'h0;
    ls_rdata_o  = 32'h0;
    if (rst_i) begin
      mem_req_o  = issue;
      if_gnt_o   = gnt_if;
      ls_gnt_o   = gnt_ls;
      if_rdata_o = mem_rdata_i;
      ls_rdata_o = mem_rdata_i;
      if (sel_ls) begin
        mem_we_o    = ls_we_i;
        mem_be_o    = ls_be_i;
        mem_addr_o  = {ls_addr_i[31:2], 2'b00};
        mem_wdata_o = ls_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = {if_addr_i[31:2], 2'b00};
      end
      ls_rvalid_o = pop & head_ls;
      // A flush arriving with the head response also kills that response.
      if_rvalid_o = pop & ~head_ls & ~head_discard & ~if_flush_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      own_ls  <= '0;
      discard <= '0;
    end else begin
      if (if_flush_i) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          if (occupied[i] && !own_ls[i]) discard[i] <= 1'b1;
        end
      end
      // The fetch granted alongside a flush is the redirected one, so it stays live.
      if (push) begin
        own_ls[wr_ptr]  <= gnt_ls;
        discard[wr_ptr] <= 1'b0;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= '0;
    end else if (gnt_if || !if_req_i) begin
      starve_cnt <= '0;
    end else if (gnt_ls && starve_cnt != STV_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

endmodule

// File: tb/tb_kamikaze_mem_arbiter.sv
// Directed bench for kamikaze_mem_arbiter; response routing is checked by a queue-based scoreboard.
module tb_kamikaze_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int vectors     = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  kamikaze_mem_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    if_req_i = 1'b0; if_flush_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic expect_ls, input logic expect_visible);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    if (expect_visible) exp_q.push_back({expect_ls, data});
  endtask

  // Scoreboard monitor: every visible response must match the head of the expected queue.
  always @(negedge clk_i) begin
    logic [32:0] got;
    logic [32:0] exp;
    if (rst_i === 1'b1 && (if_rvalid_o === 1'b1 || ls_rvalid_o === 1'b1)) begin
      vectors++;
      got = {ls_rvalid_o, (ls_rvalid_o ? ls_rdata_o : if_rdata_o)};
      if (if_rvalid_o && ls_rvalid_o) begin
        miscompares++;
        $display("FAIL resp_both: if_rvalid and ls_rvalid both high, required one");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: got owner %0b data 0x%08h, required no response", got[32], got[31:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL resp: got owner %0b data 0x%08h, required owner %0b data 0x%08h",
                   got[32], got[31:0], exp[32], exp[31:0]);
        end
      end
    end
  end

  logic order [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_i = 1'b0;
    idle();
    if_addr_i = 32'h0; ls_be_i = 4'h0; ls_addr_i = 32'h0; ls_wdata_i = 32'h0; mem_rdata_i = 32'h0;
    // Reset: outputs low even with active requests on the inputs.
    if_req_i = 1'b1; ls_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_gnts", {if_gnt_o, ls_gnt_o}, 0);
    check("rst_rdata", if_rdata_o, 0);
    next();
    rst_i = 1'b1;
    idle();

    // Single fetch, response two cycles after grant.
    if_req_i = 1'b1; if_addr_i = 32'h102; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check("t1_mem_req", mem_req_o, 1);
    check("t1_addr", mem_addr_o, 32'h100);
    check("t1_be", mem_be_o, 4'hF);
    check("t1_we", mem_we_o, 0);
    check("t1_if_gnt", if_gnt_o, 1);
    check("t1_ls_gnt", ls_gnt_o, 0);
    next(); idle();
    next();
    respond(32'hDEAD_BEEF, 1'b0, 1'b1);
    @(negedge clk_i);
    check("t1_if_rvalid", if_rvalid_o, 1);
    check("t1_ls_rvalid", ls_rvalid_o, 0);
    check("t1_rdata", if_rdata_o, 32'hDEAD_BEEF);
    next(); idle();

    // Starvation: both requesting for six cycles; LS limited to three in a row.
    if_addr_i = 32'h1004; ls_addr_i = 32'h3000;
    for (int k = 0; k < 6; k++) begin
      if_req_i = 1'b1; ls_req_i = 1'b1; mem_gnt_i = 1'b1;
      if (k > 0) respond(32'hA000_0000 + k, order[k-1], 1'b1);
      @(negedge clk_i);
      check($sformatf("t2_ls_gnt%0d", k), ls_gnt_o, order[k]);
      check($sformatf("t2_if_gnt%0d", k), if_gnt_o, !order[k]);
      check($sformatf("t2_addr%0d", k), mem_addr_o, order[k] ? 32'h3000 : 32'h1004);
      next();
    end
    idle();
    respond(32'hA000_0006, order[5], 1'b1);
    next(); idle();

    // Outstanding limit: four grants, stall, pop does not free a slot that cycle.
    if_addr_i = 32'h2000;
    for (int k = 0; k < 5; k++) begin
      if_req_i = 1'b1; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      check($sformatf("t3_mem_req%0d", k), mem_req_o, (k < 4) ? 1 : 0);
      check($sformatf("t3_if_gnt%0d", k), if_gnt_o, (k < 4) ? 1 : 0);
      next();
    end
    respond(32'hB000_0001, 1'b0, 1'b1);
    @(negedge clk_i);
    check("t3_pop_no_gnt", if_gnt_o, 0);
    next();
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("t3_after_pop_gnt", if_gnt_o, 1);
    next(); idle();
    for (int k = 0; k < 4; k++) begin
      respond(32'hB000_0010 + k, 1'b0, 1'b1);
      next();
    end
    idle();

    // Flush: IF,IF,LS outstanding, flush with a new IF grant.
    if_req_i = 1'b1; if_addr_i = 32'h400; mem_gnt_i = 1'b1;
    next();
    if_addr_i = 32'h404;
    next();
    if_req_i = 1'b0; ls_req_i = 1'b1; ls_addr_i = 32'h800;
    @(negedge clk_i);
    check("t4_ls_gnt", ls_gnt_o, 1);
    next();
    ls_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h500; if_flush_i = 1'b1;
    @(negedge clk_i);
    check("t4_flush_if_gnt", if_gnt_o, 1);
    next(); idle();
    for (int k = 0; k < 2; k++) begin
      respond(32'h11 * (k + 1), 1'b0, 1'b0);
      @(negedge clk_i);
      check($sformatf("t4_supp%0d", k), {if_rvalid_o, ls_rvalid_o}, 0);
      next();
    end
    respond(32'h33, 1'b1, 1'b1);
    @(negedge clk_i);
    check("t4_ls_rvalid", ls_rvalid_o, 1);
    next();
    respond(32'h44, 1'b0, 1'b1);
    @(negedge clk_i);
    check("t4_if_rvalid", if_rvalid_o, 1);
    next(); idle();
    // Flush in the same cycle the IF head returns.
    if_req_i = 1'b1; if_addr_i = 32'h600; mem_gnt_i = 1'b1;
    next(); idle();
    respond(32'h55, 1'b0, 1'b0);
    if_flush_i = 1'b1;
    @(negedge clk_i);
    check("t4_head_flush", if_rvalid_o, 0);
    next(); idle();

    // LS write.
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011; ls_addr_i = 32'h203;
    ls_wdata_i = 32'h1234; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check("t5_we", mem_we_o, 1);
    check("t5_be", mem_be_o, 4'h3);
    check("t5_wdata", mem_wdata_o, 32'h1234);
    check("t5_addr", mem_addr_o, 32'h200);
    check("t5_ls_gnt", ls_gnt_o, 1);
    next(); idle();
    respond(32'h0, 1'b1, 1'b1);
    @(negedge clk_i);
    check("t5_ls_rvalid", ls_rvalid_o, 1);
    next(); idle();

    // Reset with three outstanding, then empty-FIFO rvalid, then a fresh fetch.
    if_req_i = 1'b1; if_addr_i = 32'h700; mem_gnt_i = 1'b1;
    next(); next(); next();
    rst_i = 1'b0; ls_req_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check("t6_rst_mem_req", mem_req_o, 0);
    check("t6_rst_gnt", {if_gnt_o, ls_gnt_o}, 0);
    check("t6_rst_be", mem_be_o, 0);
    check("t6_rst_addr", mem_addr_o, 0);
    check("t6_rst_ls_rdata", ls_rdata_o, 0);
    next();
    rst_i = 1'b1; idle();
    respond(32'h77, 1'b0, 1'b0);
    @(negedge clk_i);
    check("t6_empty_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
    next(); idle();
    if_req_i = 1'b1; if_addr_i = 32'h900; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check("t6_if_gnt", if_gnt_o, 1);
    next(); idle();
    respond(32'h99, 1'b0, 1'b1);
    @(negedge clk_i);
    check("t6_if_rvalid", if_rvalid_o, 1);
    check("t6_ls_rvalid", ls_rvalid_o, 0);
    next(); idle();
    next();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
